// File: rtl/blk2s_post_pkg.sv
// Shared FastKDF constants and the state type of the post-PRF pointer stage.
package blk2s_post_pkg;

  localparam int unsigned OUTPUT_SIZE   = 32;
  localparam int unsigned KDF_BUF_SIZE  = 256;
  localparam int unsigned ITER_NUM      = 32;
  localparam int unsigned BYTES_PER_CYC = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold
  } post_state_e;

endpackage

// File: rtl/byte_sum_acc.sv
// Adds BYTES_PER_CYC bytes per enabled cycle into an 8-bit wrapping accumulator.
module byte_sum_acc #(
  parameter int unsigned BYTES_PER_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic [BYTES_PER_CYC*8-1:0] chunk,
  output logic [7:0]                 sum
);

  logic [7:0] chunk_sum;
  logic [7:0] sum_q;

  // Carries beyond bit 7 are dropped on purpose: the pointer is the sum mod 256.
  always_comb begin
    chunk_sum = '0;
    for (int unsigned i = 0; i < BYTES_PER_CYC; i++) begin
      chunk_sum = chunk_sum + chunk[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q + chunk_sum;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/blk2s_post.sv
// Post-PRF stage: reduces each PRF result to a buffer pointer and counts KDF iterations.
module blk2s_post #(
  parameter int unsigned OUTPUT_SIZE   = blk2s_post_pkg::OUTPUT_SIZE,
  parameter int unsigned BYTES_PER_CYC = blk2s_post_pkg::BYTES_PER_CYC,
  parameter int unsigned ITER_NUM      = blk2s_post_pkg::ITER_NUM
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [OUTPUT_SIZE*8-1:0]    prf_output,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [7:0]                  buf_ptr_out,
  output logic                        last_out,
  output logic [$clog2(ITER_NUM)-1:0] iter_cnt
);

  import blk2s_post_pkg::*;

  localparam int unsigned NumChunks = OUTPUT_SIZE / BYTES_PER_CYC;
  localparam int unsigned ChunkW    = BYTES_PER_CYC * 8;
  localparam int unsigned ChunkIdxW = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned IterW     = $clog2(ITER_NUM);

  post_state_e              state_q, state_d;
  logic [OUTPUT_SIZE*8-1:0] data_q;
  logic [ChunkIdxW-1:0]     chunk_idx_q;
  logic [IterW-1:0]         iter_q;
  logic                     accept, last_chunk, handshake;
  logic                     acc_clr, acc_en;
  logic [7:0]               sum;

  assign accept     = (state_q == StIdle) && in_vld;
  assign last_chunk = (chunk_idx_q == ChunkIdxW'(NumChunks - 1));
  assign handshake  = (state_q == StHold) && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (in_vld) state_d = StAcc;
        StAcc:   if (last_chunk) state_d = StHold;
        StHold:  if (out_rdy) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    in_rdy      = (state_q == StIdle);
    out_vld     = (state_q == StHold);
    last_out    = out_vld && (iter_q == IterW'(ITER_NUM - 1));
    buf_ptr_out = sum;
    iter_cnt    = iter_q;
  end

  // The captured result is shifted down one chunk per ACC cycle, so the
  // accumulator always reads the low chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      chunk_idx_q <= '0;
      iter_q      <= '0;
    end else if (flush) begin
      data_q      <= '0;
      chunk_idx_q <= '0;
      iter_q      <= '0;
    end else begin
      if (accept) begin
        data_q      <= prf_output;
        chunk_idx_q <= '0;
      end else if (state_q == StAcc) begin
        data_q      <= data_q >> ChunkW;
        chunk_idx_q <= last_chunk ? '0 : chunk_idx_q + 1'b1;
      end
      if (handshake) begin
        iter_q <= (iter_q == IterW'(ITER_NUM - 1)) ? '0 : iter_q + 1'b1;
      end
    end
  end

  assign acc_clr = flush || accept;
  assign acc_en  = (state_q == StAcc) && !flush;

  byte_sum_acc #(
    .BYTES_PER_CYC(BYTES_PER_CYC)
  ) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc_clr),
    .en   (acc_en),
    .chunk(data_q[ChunkW-1:0]),
    .sum  (sum)
  );

endmodule

// File: tb/tb_blk2s_post.sv
// Directed bench for blk2s_post with a transaction-level reference model.
module tb_blk2s_post;

  localparam int unsigned OutSize = 32;
  localparam int unsigned IterNum = 32;
  localparam int unsigned Latency = 8;  // edges from accept until the pointer is presented

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_vld = 1'b0;
  logic               in_rdy;
  logic [OutSize*8-1:0] prf_output = '0;
  logic               out_vld;
  logic               out_rdy = 1'b1;
  logic [7:0]         buf_ptr_out;
  logic               last_out;
  logic [4:0]         iter_cnt;

  int n_chk = 0;
  int n_fail = 0;

  blk2s_post dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .prf_output (prf_output),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .buf_ptr_out(buf_ptr_out),
    .last_out   (last_out),
    .iter_cnt   (iter_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_sum(input logic [OutSize*8-1:0] d);
    int s = 0;
    for (int k = 0; k < OutSize; k++) s += int'(d[k*8 +: 8]);
    return 8'(s % 256);
  endfunction

  function automatic logic [OutSize*8-1:0] fill(input logic [7:0] b);
    logic [OutSize*8-1:0] d;
    for (int k = 0; k < OutSize; k++) d[k*8 +: 8] = b;
    return d;
  endfunction

  function automatic logic [OutSize*8-1:0] ramp(input logic [7:0] base);
    logic [OutSize*8-1:0] d;
    for (int k = 0; k < OutSize; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result is busy from accept until its pointer is taken.
  logic       m_busy;
  int         m_wait;
  logic [7:0] m_ptr;
  int         m_iter;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_wait <= 0;
      m_ptr  <= '0;
      m_iter <= 0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_iter <= 0;
    end else if (!m_busy) begin
      if (in_vld) begin
        m_busy <= 1'b1;
        m_wait <= Latency;
        m_ptr  <= byte_sum(prf_output);
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (out_rdy) begin
      m_busy <= 1'b0;
      m_iter <= (m_iter + 1) % IterNum;
    end
  end

  always @(negedge clk) begin
    logic exp_vld;
    exp_vld = m_busy && (m_wait == 0);
    chk("mdl_in_rdy", 32'(in_rdy), 32'(!m_busy));
    chk("mdl_out_vld", 32'(out_vld), 32'(exp_vld));
    chk("mdl_iter_cnt", 32'(iter_cnt), 32'(m_iter));
    chk("mdl_last_out", 32'(last_out), 32'(exp_vld && (m_iter == IterNum - 1)));
    if (exp_vld) chk("mdl_buf_ptr", 32'(buf_ptr_out), 32'(m_ptr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [OutSize*8-1:0] d);
    int n = 0;
    while (!in_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!in_rdy) chk("send_timeout", 32'(in_rdy), 32'd1);
    in_vld     = 1'b1;
    prf_output = d;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wait_vld(output int cyc);
    cyc = 0;
    while (!out_vld && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!out_vld) chk("vld_timeout", 32'(out_vld), 32'd1);
  endtask

  task automatic run_iter(input logic [OutSize*8-1:0] d, output logic [7:0] ptr,
                          output logic last);
    int cyc;
    send(d);
    wait_vld(cyc);
    ptr  = buf_ptr_out;
    last = last_out;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int         cyc;
    logic [7:0] ptr, hold_ptr;
    logic       last;
    int         n_last, last_idx;

    #12;
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_buf_ptr", 32'(buf_ptr_out), 32'd0);
    chk("reset_iter_cnt", 32'(iter_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // All-ones bytes: latency counted from the accept cycle, single-cycle valid
    send(fill(8'h01));
    wait_vld(cyc);
    chk("ones_latency", 32'(cyc + 1), 32'd9);
    chk("ones_ptr", 32'(buf_ptr_out), 32'h20);
    tick();
    chk("ones_vld_width", 32'(out_vld), 32'd0);
    chk("ones_in_rdy_back", 32'(in_rdy), 32'd1);

    run_iter(fill(8'hFF), ptr, last);
    chk("ff_ptr", 32'(ptr), 32'hE0);
    run_iter(ramp(8'h00), ptr, last);
    chk("ramp_ptr", 32'(ptr), 32'hF0);

    // Back-pressure with ignored input pulses
    out_rdy = 1'b0;
    send(fill(8'h03));
    wait_vld(cyc);
    hold_ptr = buf_ptr_out;
    chk("hold_ptr", 32'(hold_ptr), 32'h60);
    for (int i = 0; i < 20; i++) begin
      in_vld     = (i % 2 == 0);
      prf_output = fill(8'hAA);
      tick();
      chk("hold_vld", 32'(out_vld), 32'd1);
      chk("hold_ptr_stable", 32'(buf_ptr_out), 32'(hold_ptr));
      chk("hold_in_rdy", 32'(in_rdy), 32'd0);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    tick();
    chk("hold_release", 32'(out_vld), 32'd0);

    // 33 back-to-back iterations from a clean count
    do_flush();
    n_last   = 0;
    last_idx = -1;
    for (int i = 0; i < 33; i++) begin
      run_iter(ramp(8'(i)), ptr, last);
      if (last) begin
        n_last++;
        last_idx = i;
      end
      if (i == 31) chk("wrap_iter_cnt", 32'(iter_cnt), 32'd0);
      if (i == 32) chk("iter33_last", 32'(last), 32'd0);
    end
    chk("last_count", 32'(n_last), 32'd1);
    chk("last_index", 32'(last_idx), 32'd31);

    // Asynchronous reset in the middle of accumulation
    send(fill(8'h05));
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_in_rdy", 32'(in_rdy), 32'd1);
    chk("arst_iter_cnt", 32'(iter_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_iter(ramp(8'h00), ptr, last);
    chk("arst_next_ptr", 32'(ptr), 32'hF0);

    // Flush while holding the pointer of iteration 10
    do_flush();
    for (int i = 0; i < 10; i++) run_iter(fill(8'(i)), ptr, last);
    chk("pre_flush_iter", 32'(iter_cnt), 32'd10);
    out_rdy = 1'b0;
    send(fill(8'h07));
    wait_vld(cyc);
    do_flush();
    chk("flush_out_vld", 32'(out_vld), 32'd0);
    chk("flush_iter_cnt", 32'(iter_cnt), 32'd0);
    chk("flush_in_rdy", 32'(in_rdy), 32'd1);
    out_rdy  = 1'b1;
    n_last   = 0;
    last_idx = -1;
    for (int i = 0; i < 32; i++) begin
      run_iter(ramp(8'(3 * i)), ptr, last);
      if (last) begin
        n_last++;
        last_idx = i;
      end
    end
    chk("post_flush_last_count", 32'(n_last), 32'd1);
    chk("post_flush_last_index", 32'(last_idx), 32'd31);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
